// File: rtl/spi_stream_arbiter.sv
// ============================================================================
// Module   : spi_stream_arbiter
// Purpose  : Chooses one DATA_FSM transfer at a time between audio FIFO refill
//            and video bank requests, with a chip-select gap and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_stream_arbiter #(
  parameter int AUD_LOW_WATER  = 64,
  parameter int AUD_HIGH_WATER = 192,
  parameter int MAX_AUD_RUN    = 4,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLK_40,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       vid_req,
  input  logic [8:0] aud_level,
  input  logic       xfer_done,
  output logic       start_req,
  output logic       xfer_is_audio,
  output logic       xfer_active,
  output logic       vid_ack,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT = 2'd1;
  localparam logic [1:0] c_XFER  = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  localparam int c_TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_GAP_LEN = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam int c_GAP_W   = $clog2(c_GAP_LEN + 1);
  localparam int c_RUN_W   = $clog2(MAX_AUD_RUN + 1);

  localparam logic [8:0]         c_LOW_WATER  = 9'(AUD_LOW_WATER);
  localparam logic [8:0]         c_HIGH_WATER = 9'(AUD_HIGH_WATER);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'(c_GAP_LEN - 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX    = c_RUN_W'(MAX_AUD_RUN);

  logic [1:0]         r_state;
  logic               r_armed;
  logic               r_vid_pending;
  logic [c_RUN_W-1:0] r_aud_run;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [c_GAP_W-1:0] r_gap_cnt;
  logic               r_xfer_is_audio;
  logic               r_timeout_err;
  logic [7:0]         r_err_count;

  logic w_aud_need;
  logic w_aud_urgent;
  logic w_pick;
  logic w_pick_audio;
  logic w_vid_grant;
  logic w_aud_grant;
  logic w_done;
  logic w_timeout;

  assign w_aud_need   = (aud_level < c_HIGH_WATER);
  assign w_aud_urgent = (aud_level < c_LOW_WATER);

  // r_armed holds off the first decision until one edge after reset release
  always_comb begin
    w_pick       = 1'b0;
    w_pick_audio = 1'b0;
    if ((r_state == c_IDLE) && enable && r_armed) begin
      if (r_vid_pending && (r_aud_run == c_RUN_MAX)) begin
        w_pick = 1'b1;
      end else if (w_aud_urgent) begin
        w_pick       = 1'b1;
        w_pick_audio = 1'b1;
      end else if (r_vid_pending) begin
        w_pick = 1'b1;
      end else if (w_aud_need) begin
        w_pick       = 1'b1;
        w_pick_audio = 1'b1;
      end
    end
  end

  assign w_vid_grant = w_pick & ~w_pick_audio;
  assign w_aud_grant = w_pick &  w_pick_audio;
  assign w_done      = (r_state == c_XFER) && xfer_done;
  assign w_timeout   = (r_state == c_XFER) && !xfer_done && (r_tmo_cnt == c_TMO_LAST);

  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= c_IDLE;
      r_armed         <= 1'b0;
      r_tmo_cnt       <= '0;
      r_gap_cnt       <= '0;
      r_xfer_is_audio <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        c_IDLE: begin
          if (w_pick) begin
            r_state         <= c_GRANT;
            r_xfer_is_audio <= w_pick_audio;
            r_tmo_cnt       <= '0;
          end
        end
        c_GRANT: begin
          r_state   <= c_XFER;
          r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
        c_XFER: begin
          if (w_done || w_timeout) begin
            r_state   <= c_GAP;
            r_gap_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
          end
        end
        default: begin
          if (r_gap_cnt == c_GAP_LAST) begin
            r_state <= c_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
          end
        end
      endcase
    end
  end

  // A new request wins over a same-cycle grant; a timed-out video transfer re-arms itself
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_pending <= 1'b0;
      r_aud_run     <= '0;
      r_timeout_err <= 1'b0;
      r_err_count   <= 8'd0;
    end else begin
      if (vid_req || (w_timeout && !r_xfer_is_audio)) begin
        r_vid_pending <= 1'b1;
      end else if (w_vid_grant) begin
        r_vid_pending <= 1'b0;
      end

      if (w_vid_grant || !r_vid_pending) begin
        r_aud_run <= '0;
      end else if (w_aud_grant && (r_aud_run != c_RUN_MAX)) begin
        r_aud_run <= r_aud_run + c_RUN_W'(1);
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
    end
  end

  assign start_req     = (r_state == c_GRANT);
  assign xfer_active   = (r_state == c_GRANT) || (r_state == c_XFER);
  assign vid_ack       = w_done && !r_xfer_is_audio;
  assign xfer_is_audio = r_xfer_is_audio;
  assign timeout_err   = r_timeout_err;
  assign err_count     = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_spi_stream_arbiter.sv
// ============================================================================
// Module   : tb_spi_stream_arbiter
// Purpose  : Self-checking bench for spi_stream_arbiter against a cycle-count
//            reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_stream_arbiter;

  localparam int LOW  = 64;
  localparam int HIGH = 192;
  localparam int MAXR = 4;
  localparam int GAP  = 8;
  localparam int TMO  = 50;

  logic       CLK_40 = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       vid_req = 1'b0;
  logic [8:0] aud_level = 9'd0;
  logic       xfer_done = 1'b0;
  logic       start_req;
  logic       xfer_is_audio;
  logic       xfer_active;
  logic       vid_ack;
  logic       timeout_err;
  logic [7:0] err_count;

  always #12.5 CLK_40 = ~CLK_40;

  spi_stream_arbiter #(
    .AUD_LOW_WATER (LOW),
    .AUD_HIGH_WATER(HIGH),
    .MAX_AUD_RUN   (MAXR),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK_40       (CLK_40),
    .reset_n      (reset_n),
    .enable       (enable),
    .vid_req      (vid_req),
    .aud_level    (aud_level),
    .xfer_done    (xfer_done),
    .start_req    (start_req),
    .xfer_is_audio(xfer_is_audio),
    .xfer_active  (xfer_active),
    .vid_ack      (vid_ack),
    .timeout_err  (timeout_err),
    .err_count    (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s_cyc    = 0;

  // model: transfer bookkeeping expressed as absolute cycle numbers
  bit m_busy  = 0;
  bit m_isaud = 0;
  bit m_pend  = 0;
  bit m_err   = 0;
  int m_run   = 0;
  int m_cnt   = 0;
  int m_gcyc  = 0;
  int m_ready = 0;

  // {start_req, xfer_active, vid_ack, xfer_is_audio, timeout_err, err_count}
  logic [12:0] act;
  logic [12:0] exp;

  int rsp_g = -1000;
  int rsp_d = 0;

  function automatic int pick(input bit pend, input int run, input int lvl);
    if (pend && run == MAXR) return 2;
    if (lvl < LOW)           return 1;
    if (pend)                return 2;
    if (lvl < HIGH)          return 1;
    return 0;
  endfunction

  task automatic tick();
    int tgt;
    bit fin;
    bit tmo;
    #1;
    if (!reset_n) begin
      m_busy = 0; m_isaud = 0; m_pend = 0; m_err = 0;
      m_run = 0; m_cnt = 0; m_ready = cyc + 2;
    end
    act = {start_req, xfer_active, vid_ack, xfer_is_audio, timeout_err, err_count};
    exp = {m_busy && (cyc == m_gcyc), m_busy && (cyc >= m_gcyc),
           m_busy && (cyc > m_gcyc) && xfer_done && !m_isaud,
           m_isaud, m_err, 8'(m_cnt)};
    if (reset_n) begin
      fin = 0; tmo = 0; tgt = 0;
      if (m_busy && cyc > m_gcyc) begin
        if (xfer_done) fin = 1;
        else if (cyc - m_gcyc == TMO - 1) begin fin = 1; tmo = 1; end
      end
      if (!m_busy && cyc >= m_ready && enable) tgt = pick(m_pend, m_run, int'(aud_level));
      if (tgt == 2 || !m_pend) m_run = 0;
      else if (tgt == 1 && m_run < MAXR) m_run++;
      m_pend = vid_req || (tmo && !m_isaud) || (m_pend && tgt != 2);
      if (tmo) begin m_err = 1; if (m_cnt < 255) m_cnt++; end
      if (fin) begin m_busy = 0; m_ready = cyc + ((GAP == 0) ? 1 : GAP) + 1; end
      if (tgt != 0) begin m_busy = 1; m_gcyc = cyc + 1; m_isaud = (tgt == 1); end
    end
    s_cyc = cyc;
    @(posedge CLK_40);
    #1;
    cyc++;
  endtask

  // DATA_FSM stand-in: completes each started transfer d cycles after start_req (d=0: never)
  task automatic drive_done(input int d);
    if (start_req === 1'b1) begin rsp_g = cyc; rsp_d = d; end
    xfer_done = (rsp_d > 0) && (cyc == rsp_g + rsp_d);
  endtask

  task automatic do_reset();
    reset_n = 0; vid_req = 0; xfer_done = 0; enable = 0; rsp_d = 0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int j;
    int first_g;
    reset_n = 0;
    for (int i = 0; i < 6; i++) begin
      enable = 1'($urandom); vid_req = 1'($urandom); xfer_done = 1'($urandom);
      aud_level = 9'($urandom_range(0, 256));
      tick();
      n_checks++;
      if (act !== 13'h0) begin n_fail++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", s_cyc, act, 13'h0); end
    end
    enable = 1; vid_req = 0; xfer_done = 0; aud_level = 0; rsp_d = 0;
    j = cyc; first_g = -1; reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12] && first_g < 0) first_g = s_cyc;
    end
    n_checks++;
    if (first_g < j + 2) begin n_fail++; $display("FAIL first_grant_edge got=%0d exp>=2", first_g - j); end
  endtask

  task automatic test_video_single();
    int ng = 0, na = 0, g = 0, a = 0, gaud = 1;
    do_reset();
    aud_level = 200; enable = 1; reset_n = 1;
    for (int i = 0; i < 90; i++) begin
      vid_req = (i == 0);
      drive_done(40);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL video_single cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12]) begin ng++; g = s_cyc; gaud = act[9]; end
      if (act[10]) begin na++; a = s_cyc; end
    end
    n_checks++;
    if (ng !== 1 || gaud !== 0) begin n_fail++; $display("FAIL video_single_grants got=%0d/aud%0d exp=1/aud0", ng, gaud); end
    n_checks++;
    if (na !== 1 || a - g !== 40) begin n_fail++; $display("FAIL video_single_ack got=%0d@%0d exp=1@40", na, a - g); end
  endtask

  task automatic test_audio_run();
    logic [9:0] seq = '0;
    int ng = 0, last_g = 0, min_sp = 100000, max_sp = 0;
    do_reset();
    aud_level = 10; enable = 1; vid_req = 1; reset_n = 1;
    for (int i = 0; i < 330; i++) begin
      drive_done(20);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL audio_run cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12]) begin
        if (ng < 10) seq[9 - ng] = act[9];
        if (ng > 0) begin
          if (s_cyc - last_g < min_sp) min_sp = s_cyc - last_g;
          if (s_cyc - last_g > max_sp) max_sp = s_cyc - last_g;
        end
        last_g = s_cyc; ng++;
      end
    end
    vid_req = 0;
    n_checks++;
    if (ng < 10 || seq !== 10'b1111011110) begin n_fail++; $display("FAIL audio_run_seq got=%b n=%0d exp=1111011110", seq, ng); end
    n_checks++;
    if (min_sp !== 30 || max_sp !== 30) begin n_fail++; $display("FAIL grant_spacing got=%0d..%0d exp=30", min_sp, max_sp); end
  endtask

  task automatic test_same_cycle();
    int ng = 0, nv = 0, g1 = 0, g2 = 0;
    do_reset();
    aud_level = 200; enable = 1; reset_n = 1;
    for (int i = 0; i < 90; i++) begin
      vid_req = (i == 0) || (i == 1);
      drive_done(15);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL same_cycle cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12]) begin
        if (ng == 0) g1 = s_cyc; else g2 = s_cyc;
        ng++; if (!act[9]) nv++;
      end
    end
    n_checks++;
    if (ng !== 2 || nv !== 2) begin n_fail++; $display("FAIL same_cycle_grants got=%0d/%0dvid exp=2/2vid", ng, nv); end
    n_checks++;
    if (g2 - g1 !== 25) begin n_fail++; $display("FAIL same_cycle_spacing got=%0d exp=25", g2 - g1); end
  endtask

  task automatic test_timeout();
    int ng = 0, na = 0, g1 = 0, g2 = 0, g2aud = 1, rise = -1, cnt_at = 0;
    do_reset();
    aud_level = 200; enable = 1; reset_n = 1;
    for (int i = 0; i < 75; i++) begin
      vid_req = (i == 0);
      drive_done(0);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL timeout cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12]) begin
        if (ng == 0) g1 = s_cyc; else begin g2 = s_cyc; g2aud = act[9]; end
        ng++;
      end
      if (act[8] && rise < 0) begin rise = s_cyc; cnt_at = act[7:0]; end
      if (act[10]) na++;
    end
    n_checks++;
    if (rise - g1 !== 50 || cnt_at !== 1) begin n_fail++; $display("FAIL timeout_flag got=%0d/cnt%0d exp=50/cnt1", rise - g1, cnt_at); end
    n_checks++;
    if (na !== 0) begin n_fail++; $display("FAIL timeout_no_ack got=%0d exp=0", na); end
    n_checks++;
    if (ng !== 2 || g2 - g1 !== 59 || g2aud !== 0) begin
      n_fail++; $display("FAIL timeout_retry got=n%0d/%0d/aud%0d exp=n2/59/aud0", ng, g2 - g1, g2aud);
    end
  endtask

  task automatic test_enable();
    int ng_off = 0, ng = 0, nv = 0, first_aud = 0;
    do_reset();
    enable = 0; aud_level = 0; reset_n = 1;
    for (int i = 0; i < 30; i++) begin
      vid_req = (i == 3) || (i == 10);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL enable_off cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12]) ng_off++;
    end
    vid_req = 0; enable = 1;
    for (int i = 0; i < 170; i++) begin
      drive_done(10);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL enable_on cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (act[12]) begin
        if (ng == 0) first_aud = act[9];
        ng++; if (!act[9]) nv++;
      end
    end
    n_checks++;
    if (ng_off !== 0) begin n_fail++; $display("FAIL enable_block got=%0d exp=0", ng_off); end
    n_checks++;
    if (first_aud !== 1 || nv !== 1) begin n_fail++; $display("FAIL enable_order got=aud%0d/%0dvid exp=aud1/1vid", first_aud, nv); end
  endtask

  task automatic test_reset_mid();
    int ng_after = 0, na = 0;
    logic [12:0] at_rst = '1;
    do_reset();
    aud_level = 100; enable = 1; reset_n = 1;
    for (int i = 0; i < 45; i++) begin
      vid_req   = (i == 5);
      if (i == 5) aud_level = 200;
      reset_n   = !(i == 9 || i == 10);
      xfer_done = (i == 13);
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
      if (i == 9) at_rst = act;
      if (i >= 9 && act[12]) ng_after++;
      if (act[10]) na++;
    end
    n_checks++;
    if (at_rst !== 13'h0) begin n_fail++; $display("FAIL reset_abort got=%h exp=%h", at_rst, 13'h0); end
    n_checks++;
    if (ng_after !== 0 || na !== 0) begin n_fail++; $display("FAIL reset_drop got=%0dgnt/%0dack exp=0/0", ng_after, na); end
  endtask

  task automatic test_random();
    do_reset();
    reset_n = 1;
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 999) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      vid_req = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) aud_level = 9'($urandom_range(0, 256));
      drive_done($urandom_range(1, 60));
      if ($urandom_range(0, 63) == 0) xfer_done = 1;
      tick();
      n_checks++;
      if (act !== exp) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", s_cyc, act, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_video_single();
    test_audio_run();
    test_same_cycle();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
